alu_seq: RTL and testbench

- Parametrised, registered successor to the team's 4-bit combinational ALU.
- WIDTH-bit operands, same 16-entry opcode map, valid/ready handshakes on input and output, and status flags.
- Divide and modulo use an iterative restoring divider (WIDTH cycles), replacing the combinational "/" and "%".
- Sits between an operand/opcode source and a result consumer in datapath test designs.

---
 rtl/alu_seq.sv | 213 +++++++++++++++++++++
 tb/tb_alu_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with valid/ready handshakes and status flags.
// Divide and modulo run on an iterative restoring divider, one quotient bit per cycle.
module alu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             ovf,
    output logic             dz,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned MSB = WIDTH - 1;

    typedef enum logic [1:0] {StIdle, StDiv, StDone} state_e;

    state_e           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] div_q, div_d;   // divisor copy
    logic [WIDTH-1:0] quo_q, quo_d;   // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             dz_q, dz_d;

    // Single-cycle datapath on the live inputs
    logic [WIDTH-1:0]   op_res;
    logic               op_carry, op_ovf, op_dz;
    logic [WIDTH:0]     sum_ext;
    logic [2*WIDTH-1:0] prod;
    logic               is_div;

    always_comb begin
        op_res   = '0;
        op_carry = 1'b0;
        op_ovf   = 1'b0;
        op_dz    = 1'b0;
        sum_ext  = '0;
        prod     = '0;
        case (sel)
            4'h0: begin
                sum_ext  = {1'b0, a} + {1'b0, b};
                op_res   = sum_ext[WIDTH-1:0];
                op_carry = sum_ext[WIDTH];
                op_ovf   = (a[MSB] == b[MSB]) && (op_res[MSB] != a[MSB]);
            end
            4'h1: begin
                sum_ext  = {1'b0, a} - {1'b0, b};
                op_res   = sum_ext[WIDTH-1:0];
                op_carry = sum_ext[WIDTH];
                op_ovf   = (a[MSB] != b[MSB]) && (op_res[MSB] != a[MSB]);
            end
            4'h2: begin
                prod   = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
                op_res = prod[WIDTH-1:0];
                op_ovf = |prod[2*WIDTH-1:WIDTH];
            end
            // Only reached with b == 0; nonzero divisors go to the divider
            4'h3: begin
                op_res = '1;
                op_dz  = 1'b1;
            end
            4'h4: op_res = ~a;
            4'h5: op_res = a & b;
            4'h6: op_res = a | b;
            4'h7: op_res = ~(a & b);
            4'h8: op_res = ~(a | b);
            4'h9: op_res = a ^ b;
            4'hA: op_res = ~(a ^ b);
            4'hB: begin
                op_res = a;
                op_dz  = 1'b1;
            end
            4'hC: begin
                sum_ext  = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
                op_res   = sum_ext[WIDTH-1:0];
                op_carry = sum_ext[WIDTH];
                op_ovf   = op_res[MSB] & ~a[MSB];
            end
            4'hD: begin
                sum_ext  = {1'b0, a} - {{WIDTH{1'b0}}, 1'b1};
                op_res   = sum_ext[WIDTH-1:0];
                op_carry = sum_ext[WIDTH];
                op_ovf   = a[MSB] & ~op_res[MSB];
            end
            4'hE: begin
                op_res    = '0;
                op_res[0] = (a == '0);
            end
            default: op_res = b;
        endcase
    end

    assign is_div = ((sel == 4'h3) || (sel == 4'hB)) && (b != '0);

    // Restoring divider step
    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH-1:0] rem_nx, quo_nx;

    always_comb begin
        shifted = {rem_q, quo_q[MSB]};
        ge      = (shifted >= {1'b0, div_q});
        // rem < divisor, so the difference fits in WIDTH bits whenever ge holds
        rem_nx  = ge ? (shifted[WIDTH-1:0] - div_q) : shifted[WIDTH-1:0];
        quo_nx  = {quo_q[WIDTH-2:0], ge};
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        div_d   = div_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        dz_d    = dz_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    op_d  = sel;
                    div_d = b;
                    if (is_div) begin
                        quo_d   = a;
                        rem_d   = '0;
                        cnt_d   = CW'(WIDTH - 1);
                        state_d = StDiv;
                    end else begin
                        res_d   = op_res;
                        zero_d  = (op_res == '0);
                        carry_d = op_carry;
                        ovf_d   = op_ovf;
                        dz_d    = op_dz;
                        state_d = StDone;
                    end
                end
            end
            StDiv: begin
                quo_d = quo_nx;
                rem_d = rem_nx;
                if (cnt_q == '0) begin
                    res_d   = (op_q == 4'h3) ? quo_nx : rem_nx;
                    zero_d  = ((op_q == 4'h3) ? quo_nx : rem_nx) == '0;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    dz_d    = 1'b0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            op_q    <= '0;
            div_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            div_q   <= div_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
        end
    end

    assign in_ready  = (state_q == StIdle) && !rst;
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign result    = res_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign ovf       = ovf_q;
    assign dz        = dz_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): hand vectors, corner sequences,
// and randomized operations against an arithmetic reference model.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] a, b, result;
    logic [3:0] sel;
    logic       zero, carry, ovf, dz, busy;

    int total = 0;
    int bad   = 0;

    alu_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .carry(carry), .ovf(ovf), .dz(dz), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] s;
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] r;
        logic [3:0] f;   // {zero, carry, ovf, dz}
        int         lat;
    } vec_t;

    typedef struct {
        logic [7:0] r;
        logic [3:0] f;
        int         lat;
    } exp_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    function automatic int sgn(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    function automatic exp_t model(input logic [3:0] s, input logic [7:0] x, input logic [7:0] y);
        exp_t e;
        int ia = int'(x);
        int ib = int'(y);
        int t;
        logic c = 1'b0, o = 1'b0, d = 1'b0;
        e.lat = 1;
        case (s)
            4'h0: begin t = ia + ib; c = t > 255; t = sgn(ia) + sgn(ib); o = t > 127 || t < -128; e.r = 8'(ia + ib); end
            4'h1: begin c = ia < ib; t = sgn(ia) - sgn(ib); o = t > 127 || t < -128; e.r = 8'(ia - ib + 256); end
            4'h2: begin t = ia * ib; o = t > 255; e.r = 8'(t % 256); end
            4'h3: if (ib == 0) begin e.r = 8'd255; d = 1'b1; end else begin e.r = 8'(ia / ib); e.lat = 9; end
            4'h4: e.r = ~x;
            4'h5: e.r = x & y;
            4'h6: e.r = x | y;
            4'h7: e.r = ~(x & y);
            4'h8: e.r = ~(x | y);
            4'h9: e.r = x ^ y;
            4'hA: e.r = ~(x ^ y);
            4'hB: if (ib == 0) begin e.r = x; d = 1'b1; end else begin e.r = 8'(ia % ib); e.lat = 9; end
            4'hC: begin c = ia == 255; o = sgn(ia) + 1 > 127; e.r = 8'(ia + 1); end
            4'hD: begin c = ia == 0; o = sgn(ia) - 1 < -128; e.r = 8'(ia + 255); end
            4'hE: e.r = (ia == 0) ? 8'd1 : 8'd0;
            default: e.r = y;
        endcase
        e.f = {e.r == 8'd0, c, o, d};
        return e;
    endfunction

    // Issue one op, measure latency to out_valid, optionally stall the consumer.
    task automatic do_op(input logic [3:0] s, input logic [7:0] x, input logic [7:0] y,
                         input int hold, output logic [7:0] r, output logic [3:0] f,
                         output int lat);
        @(negedge clk);
        check("in_ready_before_op", in_ready, 1);
        in_valid  = 1'b1;
        sel       = s;
        a         = x;
        b         = y;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 8'($urandom);
        b        = 8'($urandom);
        sel      = 4'($urandom);
        lat      = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
            check("in_ready_low_while_div", in_ready, 0);
            check("busy_while_div", busy, 1);
        end
        check("out_valid_seen", out_valid, 1);
        r = result;
        f = {zero, carry, ovf, dz};
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("stall_result_stable", result, r);
            check("stall_in_ready_low", in_ready, 0);
            check("stall_out_valid_high", out_valid, 1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("idle_after_accept", {in_ready, out_valid, busy}, 3'b100);
        check("result_kept_after_accept", result, r);
    endtask

    vec_t       vecs[15];
    exp_t       e;
    logic [7:0] r;
    logic [3:0] f;
    int         lat;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{4'h0, 8'd200, 8'd100, 8'd44,  4'b0100, 1};
        vecs[1]  = '{4'h1, 8'd5,   8'd7,   8'd254, 4'b0100, 1};
        vecs[2]  = '{4'hD, 8'h80,  8'd0,   8'h7F,  4'b0010, 1};
        vecs[3]  = '{4'h3, 8'd100, 8'd7,   8'd14,  4'b0000, 9};
        vecs[4]  = '{4'hB, 8'd100, 8'd7,   8'd2,   4'b0000, 9};
        vecs[5]  = '{4'h3, 8'd9,   8'd0,   8'd255, 4'b0001, 1};
        vecs[6]  = '{4'hB, 8'd9,   8'd0,   8'd9,   4'b0001, 1};
        vecs[7]  = '{4'h2, 8'd16,  8'd20,  8'd64,  4'b0010, 1};
        vecs[8]  = '{4'hE, 8'd0,   8'd3,   8'd1,   4'b0000, 1};
        vecs[9]  = '{4'hE, 8'd5,   8'd3,   8'd0,   4'b1000, 1};
        vecs[10] = '{4'hC, 8'h7F,  8'd0,   8'h80,  4'b0010, 1};
        vecs[11] = '{4'hC, 8'hFF,  8'd0,   8'h00,  4'b1100, 1};
        vecs[12] = '{4'h7, 8'hFF,  8'hFF,  8'h00,  4'b1000, 1};
        vecs[13] = '{4'h3, 8'd7,   8'd9,   8'd0,   4'b1000, 9};
        vecs[14] = '{4'hB, 8'd255, 8'd16,  8'd15,  4'b0000, 9};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sel = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {in_ready, out_valid, busy, result, zero, carry, ovf, dz}, '0);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_reset", {in_ready, busy}, 2'b10);

        foreach (vecs[i]) begin
            do_op(vecs[i].s, vecs[i].x, vecs[i].y, 0, r, f, lat);
            check($sformatf("vec%0d_result", i), r, vecs[i].r);
            check($sformatf("vec%0d_flags", i), f, vecs[i].f);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
        end

        // Consumer back-pressure on a multiply
        do_op(4'h2, 8'd16, 8'd20, 5, r, f, lat);
        check("stall_mul_result", r, 8'd64);
        check("stall_mul_flags", f, 4'b0010);

        // Asynchronous reset mid-divide, after a nonzero result is on the outputs
        do_op(4'h0, 8'd1, 8'd1, 0, r, f, lat);
        check("pre_reset_result", r, 8'd2);
        @(negedge clk);
        in_valid = 1'b1; sel = 4'h3; a = 8'd200; b = 8'd3;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("busy_before_abort", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("abort_outputs_cleared",
              {in_ready, out_valid, busy, result, zero, carry, ovf, dz}, '0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_after_abort", {in_ready, busy, out_valid}, 3'b100);
        do_op(4'h0, 8'd1, 8'd1, 0, r, f, lat);
        check("post_abort_result", r, 8'd2);
        check("post_abort_latency", lat, 1);

        // Randomized operations against the reference model
        for (int n = 0; n < 200; n++) begin
            logic [3:0] s = 4'($urandom);
            logic [7:0] x = 8'($urandom);
            logic [7:0] y = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            e = model(s, x, y);
            do_op(s, x, y, $urandom_range(0, 3), r, f, lat);
            check($sformatf("rand%0d_op%0h_%0d_%0d_result", n, s, x, y), r, e.r);
            check($sformatf("rand%0d_op%0h_flags", n, s), f, e.f);
            check($sformatf("rand%0d_op%0h_latency", n, s), lat, e.lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
